// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between two requesters: accept, one-cycle execute, held response.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration (default is fixed priority to req0).
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_aluctl,
  input  logic [1:0]   req0_regctl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_aluctl,
  input  logic [1:0]   req1_regctl,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctl,
  output logic [1:0]   alu_regctl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [3:0]   alu_ctl_q, rsp_flags_q;
  logic [1:0]   alu_regctl_q;
  logic         id_q, rsp_valid_q;
  logic         any_valid, gnt_id, accept;

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
  logic rr_q;
  // Contention resolved by the pointer; a lone requester always wins.
  assign gnt_id = (req0_valid & req1_valid) ? rr_q : req1_valid;

  always_ff @(posedge clk) begin
    if (reset)       rr_q <= 1'b0;
    else if (accept) rr_q <= ~gnt_id;
  end
`else
  assign gnt_id = ~req0_valid & req1_valid;
`endif

  assign accept     = (state_q == IDLE) & any_valid & ~reset;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept &  gnt_id;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= 4'b0000;
      alu_regctl_q <= 2'b00;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q      <= gnt_id ? req1_a      : req0_a;
        alu_b_q      <= gnt_id ? req1_b      : req0_b;
        alu_ctl_q    <= gnt_id ? req1_aluctl : req0_aluctl;
        alu_regctl_q <= gnt_id ? req1_regctl : req0_regctl;
        id_q         <= gnt_id;
      end
      // ALU is combinational off alu_*; its output has settled by the end of EXEC.
      if (state_q == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_flags_q  <= alu_flags;
        rsp_valid_q  <= 1'b1;
      end
      if ((state_q == RESP) && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctl    = alu_ctl_q;
  assign alu_regctl = alu_regctl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the alu_* port.
module tb_alu_share_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_aluctl, req1_aluctl;
  logic [1:0]   req0_regctl, req1_regctl;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctl, alu_flags;
  logic [1:0]   alu_regctl;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluctl(req0_aluctl), .req0_regctl(req0_regctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluctl(req1_aluctl), .req1_regctl(req1_regctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_regctl(alu_regctl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // ALU stand-in: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR; flags {N,Z,C,V}, C/V zero for logic ops.
  logic [N:0] sum;
  logic       c_f, v_f;
  always_comb begin
    sum = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (alu_ctl)
      4'b0000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        c_f = sum[N];
        v_f = (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      4'b0001: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        c_f = sum[N];
        v_f = (alu_a[N-1] != alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      4'b0010: sum = {1'b0, alu_a & alu_b};
      4'b0011: sum = {1'b0, alu_a | alu_b};
      default: sum = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_result = sum[N-1:0];
  assign alu_flags  = {sum[N-1], sum[N-1:0] == '0, c_f, v_f};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and returns #1 after the accepting edge (DUT in EXEC).
  task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] ctl, input logic [1:0] rc);
    int n;
    if (id) begin
      req1_a = a; req1_b = b; req1_aluctl = ctl; req1_regctl = rc; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_aluctl = ctl; req0_regctl = rc; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", 64'(n < 20), 64'd1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  logic ids[$];

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_aluctl = 4'b0; req0_regctl = 2'b0;
    req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h1; req1_aluctl = 4'b0; req1_regctl = 2'b0;
    tick(); tick();
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_ctl", 64'(alu_ctl), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    #1;
    chk("idle_none_ready0", 64'(req0_ready), 64'd0);
    chk("idle_none_ready1", 64'(req1_ready), 64'd0);
    tick();

    // ADD 5+7 from req0
    issue(1'b0, 32'd5, 32'd7, 4'b0000, 2'b10);
    chk("t1_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_regctl", 64'(alu_regctl), 64'd2);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd12);
    chk("t1_flags", 64'(rsp_flags), 64'h0);
    rsp_ready = 1'b1;
    tick();
    chk("t1_rsp_drop", 64'(rsp_valid), 64'd0);

    // SUB 3-3 from req1
    issue(1'b1, 32'd3, 32'd3, 4'b0001, 2'b00);
    tick();
    chk("t2_rsp_id", 64'(rsp_id), 64'd1);
    chk("t2_result", 64'(rsp_result), 64'd0);
    chk("t2_flags", 64'(rsp_flags), 64'b0110);
    tick();
    chk("t2_rsp_drop", 64'(rsp_valid), 64'd0);
    req1_valid = 1'b1;
    #1;
    chk("t2_back_idle", 64'(req1_ready), 64'd1);
    req1_valid = 1'b0;
    tick();

    // Both valid, consumer always ready
    req0_a = 32'd1; req0_b = 32'd1; req0_aluctl = 4'b0000;
    req1_a = 32'd2; req1_b = 32'd2; req1_aluctl = 4'b0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 30 && ids.size() < 4; c++) begin
      tick();
      if (rsp_valid) ids.push_back(rsp_id);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_count", 64'(ids.size()), 64'd4);
    while (ids.size() < 4) ids.push_back(1'bx);
`ifdef ALU_ARB_RR_EN
    chk("t3_id0", 64'(ids[0]), 64'd0);
    chk("t3_id1", 64'(ids[1]), 64'd1);
    chk("t3_id2", 64'(ids[2]), 64'd0);
    chk("t3_id3", 64'(ids[3]), 64'd1);
`else
    chk("t3_id0", 64'(ids[0]), 64'd0);
    chk("t3_id1", 64'(ids[1]), 64'd0);
    chk("t3_id2", 64'(ids[2]), 64'd0);
    chk("t3_id3", 64'(ids[3]), 64'd0);
`endif
    tick();

    // ORR with response back-pressure, req1 waiting meanwhile
    rsp_ready = 1'b0;
    issue(1'b0, 32'hF0, 32'h0F, 4'b0011, 2'b00);
    req1_valid = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t4_result", 64'(rsp_result), 64'hFF);
      chk("t4_ready0", 64'(req0_ready), 64'd0);
      chk("t4_ready1", 64'(req1_ready), 64'd0);
      tick();
    end
    chk("t4_flags", 64'(rsp_flags), 64'b0000);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("t4_rsp_drop", 64'(rsp_valid), 64'd0);

    // Reset pulse while in EXEC
    issue(1'b0, 32'd9, 32'd1, 4'b0000, 2'b00);
    reset = 1'b1;
    tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_alu_a", 64'(alu_a), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req0_valid = 1'b1;
    #1;
    chk("t5_idle_ready", 64'(req0_ready), 64'd1);
    req0_valid = 1'b0;
    tick();

    // Signed overflow boundary
    issue(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0000, 2'b00);
    tick();
    chk("t6_rsp_id", 64'(rsp_id), 64'd1);
    chk("t6_result", 64'(rsp_result), 64'h8000_0000);
    chk("t6_flags", 64'(rsp_flags), 64'b1001);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
